// File: rtl/qam_pkg.sv
// Shared QAM chain definitions: symbol type, idle symbol, default timing divisors.
package qam_pkg;

   localparam int unsigned SYM_W       = 2;
   localparam int unsigned MIX_DIV_DEF = 8;
   localparam int unsigned SYM_DIV_DEF = 1000;
   localparam int unsigned UNDER_CNT_W = 8;

   typedef logic [SYM_W-1:0] sym_t;

   localparam sym_t IDLE_SYM = SYM_W'(0);

   // Registered per-cycle event bundle presented to the mixer.
   typedef struct packed {
      sym_t sym;
      logic strobe;
      logic underrun;
      logic mix_en;
   } sym_evt_t;

   localparam sym_evt_t EVT_IDLE = '{sym: IDLE_SYM, strobe: 1'b0, underrun: 1'b0, mix_en: 1'b0};

   function automatic logic is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/qam_symbol_source_if.sv
// Symbol input handshake plus the symbol/strobe bus towards the mixer.
interface qam_symbol_source_if;

   qam_pkg::sym_t in_data;
   logic          in_valid;
   logic          in_ready;
   qam_pkg::sym_t sym_out;
   logic          sym_strobe;
   logic          mix_en;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  sym_out,
      input  sym_strobe,
      input  mix_en
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output sym_out,
      output sym_strobe,
      output mix_en
   );

endinterface

// File: rtl/qam_sym_fifo.sv
// Single-clock symbol FIFO; occupancy kept in its own counter so full/empty never alias.
module qam_sym_fifo
   import qam_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  sym_t                   wr_data,
   output sym_t                   rd_data_c,
   output logic                   full_c,
   output logic                   empty_c,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   sym_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;

   assign full_c    = (level == LVL_W'(DEPTH));
   assign empty_c   = (level == '0);
   assign do_push_c = push && !full_c;
   assign do_pop_c  = pop && !empty_c;
   assign rd_data_c = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
      end
   end

endmodule

// File: rtl/qam_symbol_source.sv
// Buffered QAM symbol feed: one symbol per SYM_DIV clks plus a mixer strobe every MIX_DIV clks.
module qam_symbol_source
   import qam_pkg::*;
#(
   parameter int unsigned MIX_DIV    = MIX_DIV_DEF,
   parameter int unsigned SYM_DIV    = SYM_DIV_DEF,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        run,
   qam_symbol_source_if.slave          bus,
   output logic                        underrun,
   output logic [UNDER_CNT_W-1:0]      under_cnt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned MIX_W     = $clog2(MIX_DIV);
   localparam int unsigned SYM_CNT_W = $clog2(SYM_DIV);

   if (MIX_DIV < 2) begin : g_bad_mix_div
      $error("qam_symbol_source: MIX_DIV must be at least 2");
   end
   if ((SYM_DIV % MIX_DIV) != 0) begin : g_bad_sym_div
      $error("qam_symbol_source: SYM_DIV must be an integer multiple of MIX_DIV");
   end
   if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
      $error("qam_symbol_source: FIFO_DEPTH must be a power of two, at least 2");
   end

   logic [MIX_W-1:0]       mix_cnt;
   logic [SYM_CNT_W-1:0]   sym_cnt;
   logic                   mix_wrap_c;
   logic                   boundary_c;
   logic                   push_c;
   logic                   pop_c;
   logic                   full_c;
   logic                   empty_c;
   sym_t                   head_c;
   sym_evt_t               evt_q;
   sym_evt_t               evt_d_c;
   logic [UNDER_CNT_W-1:0] under_cnt_d_c;

   assign mix_wrap_c   = run && (mix_cnt == MIX_W'(MIX_DIV - 1));
   assign boundary_c   = run && (sym_cnt == SYM_CNT_W'(SYM_DIV - 1));
   assign bus.in_ready = rst && !full_c;
   assign push_c       = bus.in_valid && bus.in_ready;
   // Pop decision uses pre-edge occupancy, so a same-cycle push into an empty FIFO is not bypassed.
   assign pop_c        = boundary_c && !empty_c;

   qam_sym_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_c),
      .pop       (pop_c),
      .wr_data   (bus.in_data),
      .rd_data_c (head_c),
      .full_c    (full_c),
      .empty_c   (empty_c),
      .level     (fifo_level)
   );

   // Timing counters; held at zero while stopped so the first boundary lands SYM_DIV clks after run.
   always_ff @(posedge clk) begin
      if (!rst || !run) begin
         mix_cnt <= '0;
         sym_cnt <= '0;
      end else begin
         mix_cnt <= mix_wrap_c ? '0 : mix_cnt + MIX_W'(1);
         sym_cnt <= boundary_c ? '0 : sym_cnt + SYM_CNT_W'(1);
      end
   end

   always_comb begin
      evt_d_c          = EVT_IDLE;
      under_cnt_d_c    = under_cnt;
      evt_d_c.sym      = run ? evt_q.sym : IDLE_SYM;
      evt_d_c.mix_en   = mix_wrap_c;
      if (boundary_c) begin
         evt_d_c.strobe = 1'b1;
         if (empty_c) begin
            evt_d_c.sym      = IDLE_SYM;
            evt_d_c.underrun = 1'b1;
            if (under_cnt != '1) begin
               under_cnt_d_c = under_cnt + UNDER_CNT_W'(1);
            end
         end else begin
            evt_d_c.sym = head_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         evt_q     <= EVT_IDLE;
         under_cnt <= '0;
      end else begin
         evt_q     <= evt_d_c;
         under_cnt <= under_cnt_d_c;
      end
   end

   assign bus.sym_out    = evt_q.sym;
   assign bus.sym_strobe = evt_q.strobe;
   assign bus.mix_en     = evt_q.mix_en;
   assign underrun       = evt_q.underrun;

endmodule

// File: tb/tb_qam_symbol_source.sv
// Scoreboard bench for qam_symbol_source with MIX_DIV=8, SYM_DIV=32, FIFO_DEPTH=4.
module tb_qam_symbol_source;

   localparam int unsigned MIX_DIV    = 8;
   localparam int unsigned SYM_DIV    = 32;
   localparam int unsigned FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       underrun;
   logic [7:0] under_cnt;
   logic [2:0] fifo_level;

   int n_tests = 0;
   int n_fail  = 0;

   qam_symbol_source_if bus ();

   qam_symbol_source #(
      .MIX_DIV    (MIX_DIV),
      .SYM_DIV    (SYM_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .bus        (bus.slave),
      .underrun   (underrun),
      .under_cnt  (under_cnt),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO mirror fed by accepted pushes, expected outputs queued at each boundary.
   logic [1:0] fifo_q[$];
   logic [2:0] exp_q[$];
   int         m_cnt      = 0;
   logic [1:0] exp_sym    = 2'b00;
   logic       exp_strobe = 1'b0;
   logic       exp_mix    = 1'b0;
   int         m_under    = 0;

   always @(posedge clk) begin
      logic do_push;
      logic bnd;
      if (!rst) begin
         fifo_q.delete();
         exp_q.delete();
         m_cnt      = 0;
         exp_sym    = 2'b00;
         exp_strobe = 1'b0;
         exp_mix    = 1'b0;
         m_under    = 0;
      end else begin
         do_push    = bus.in_valid && (fifo_q.size() < FIFO_DEPTH);
         bnd        = run && (m_cnt == SYM_DIV - 1);
         exp_mix    = run && ((m_cnt % MIX_DIV) == MIX_DIV - 1);
         exp_strobe = bnd;
         if (bnd) begin
            if (fifo_q.size() > 0) begin
               exp_sym = fifo_q.pop_front();
               exp_q.push_back({1'b0, exp_sym});
            end else begin
               exp_sym = 2'b00;
               exp_q.push_back(3'b100);
               if (m_under < 255) m_under++;
            end
         end else if (!run) begin
            exp_sym = 2'b00;
         end
         if (do_push) fifo_q.push_back(bus.in_data);
         m_cnt = (run && m_cnt != SYM_DIV - 1) ? m_cnt + 1 : 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock, then compare every output against the model.
   task automatic tick();
      logic [2:0] e;
      @(posedge clk);
      #1;
      check("strobe", 32'(bus.sym_strobe), 32'(exp_strobe));
      check("mix_en", 32'(bus.mix_en), 32'(exp_mix));
      check("sym_out", 32'(bus.sym_out), 32'(exp_sym));
      check("level", 32'(fifo_level), 32'(fifo_q.size()));
      check("in_ready", 32'(bus.in_ready), 32'(rst && (fifo_q.size() < FIFO_DEPTH)));
      check("under_cnt", 32'(under_cnt), 32'(m_under));
      if (bus.sym_strobe) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_strobe", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("sb_sym", 32'(bus.sym_out), 32'(e[1:0]));
            check("sb_underrun", 32'(underrun), 32'(e[2]));
         end
      end else begin
         check("underrun_no_strobe", 32'(underrun), 32'd0);
      end
   endtask

   task automatic wait_strobe(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         tick();
         n++;
         if (bus.sym_strobe) return;
      end
      check("wait_strobe_timeout", 32'(bus.sym_strobe), 32'd1);
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic push_sym(input logic [1:0] s);
      bus.in_valid = 1'b1;
      bus.in_data  = s;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic [1:0] vals[5];
      int         n;

      // Reset held with in_valid asserted
      bus.in_valid = 1'b1;
      bus.in_data  = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t1_in_ready_rst", 32'(bus.in_ready), 32'd0);
      end
      check("t1_level", 32'(fifo_level), 32'd0);
      check("t1_sym", 32'(bus.sym_out), 32'd0);
      check("t1_pulses", {29'd0, bus.sym_strobe, bus.mix_en, underrun}, 32'd0);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("t1_in_ready_rel", 32'(bus.in_ready), 32'd1);

      // Stream four symbols
      push_sym(2'b01);
      push_sym(2'b10);
      push_sym(2'b11);
      push_sym(2'b00);
      run = 1'b1;
      vals[0] = 2'b01; vals[1] = 2'b10; vals[2] = 2'b11; vals[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         wait_strobe(40, n);
         check("t2_period", 32'(n), 32'(SYM_DIV));
         check("t2_sym", 32'(bus.sym_out), 32'(vals[i]));
         check("t2_mix_with_strobe", 32'(bus.mix_en), 32'd1);
      end
      wait_strobe(40, n);
      check("t2_drained_underrun", 32'(underrun), 32'd1);
      run = 1'b0;
      tick();

      // Full FIFO: fifth symbol waits for a pop
      do_reset();
      vals[0] = 2'b11; vals[1] = 2'b01; vals[2] = 2'b10; vals[3] = 2'b00; vals[4] = 2'b10;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vals[i];
         tick();
      end
      check("t3_level_full", 32'(fifo_level), 32'd4);
      check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
      run = 1'b1;
      wait_strobe(40, n);
      check("t3_first_sym", 32'(bus.sym_out), 32'(vals[0]));
      check("t3_level_after_pop", 32'(fifo_level), 32'd3);
      tick();
      bus.in_valid = 1'b0;
      check("t3_level_refill", 32'(fifo_level), 32'd4);
      for (int i = 1; i < 5; i++) begin
         wait_strobe(40, n);
         check("t3_sym", 32'(bus.sym_out), 32'(vals[i]));
      end
      run = 1'b0;
      tick();

      // Underrun counting and saturation
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_strobe(40, n);
         check("t4_underrun", 32'(underrun), 32'd1);
         check("t4_sym_idle", 32'(bus.sym_out), 32'd0);
      end
      check("t4_under_cnt3", 32'(under_cnt), 32'd3);
      for (int i = 0; i < 300; i++) wait_strobe(40, n);
      check("t4_under_sat", 32'(under_cnt), 32'd255);
      run = 1'b0;
      tick();

      // Push into empty FIFO exactly on the boundary cycle
      do_reset();
      run = 1'b1;
      n = 0;
      while (m_cnt != SYM_DIV - 1 && n < 40) begin
         tick();
         n++;
      end
      check("t5_reach_boundary", 32'(m_cnt), 32'(SYM_DIV - 1));
      push_sym(2'b11);
      check("t5_strobe", 32'(bus.sym_strobe), 32'd1);
      check("t5_underrun", 32'(underrun), 32'd1);
      check("t5_idle", 32'(bus.sym_out), 32'd0);
      check("t5_level", 32'(fifo_level), 32'd1);
      wait_strobe(40, n);
      check("t5_period", 32'(n), 32'(SYM_DIV));
      check("t5_sym", 32'(bus.sym_out), 32'd3);
      check("t5_no_underrun", 32'(underrun), 32'd0);
      run = 1'b0;
      tick();

      // Reset mid-run discards FIFO and restarts timing
      do_reset();
      push_sym(2'b01);
      push_sym(2'b10);
      push_sym(2'b11);
      run = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("t6_level3", 32'(fifo_level), 32'd3);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("t6_level0", 32'(fifo_level), 32'd0);
      check("t6_sym_idle", 32'(bus.sym_out), 32'd0);
      wait_strobe(40, n);
      check("t6_period", 32'(n), 32'(SYM_DIV));
      check("t6_underrun", 32'(underrun), 32'd1);
      run = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
